execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 16 bits and register index width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 wbs_in, mm_in, wm_in, ni_in, wme_in  input  1 each  decode-stage control bits carried to memory stage.
REQ-005 ALUop_in  input  3  decode-stage ALU operation select.
REQ-006 am_in  input  1  decode-stage srcB routing select (0 = address/read path, 1 = store-data path).
REQ-007 alu_mux_in  input  1  decode-stage result select (0 = ALU result, 1 = routed srcB).
REQ-008 reg_dest_in  input  4  decode-stage destination register index.
REQ-009 srcA_in, srcB_in  input  16 each  decode-stage operands.
REQ-010 srcB_execute  output  16  registered srcB in execute stage (PC jump target).
REQ-011 flagN, flagZ  output  1 each  combinational flags of the execute-stage ALU result.
REQ-012 wbs_out, mm_out, wm_out, ni_out, wme_out  output  1 each  memory-stage copies of the control bits.
REQ-013 ALUresult_out  output  16  memory-stage result/address.
REQ-014 memData_out  output  16  memory-stage store data.
REQ-015 reg_dest_out  output  4  memory-stage destination index.

Function
REQ-016 Stage 1 (decode/execute register) SHALL capture every *_in signal on each rising clk when reset is low.
REQ-017 The ALU SHALL be combinational on the stage-1 ALUop, srcA (A) and srcB (B), producing a 16-bit result with modulo-2^16 wrap and no carry or overflow output.
REQ-018 ALUop encoding: 000 A+B; 001 A-B; 010 A AND B; 011 A OR B; 100 A XOR B; 101 A << B[3:0]; 110 A >> B[3:0] (logical); 111 result = B.
REQ-019 flagN SHALL equal result[15]; flagZ SHALL be 1 exactly when result == 16'h0000.
REQ-020 Routed-B split: when stage-1 am=0, read path = B and store path = 0; when am=1, read path = 0 and store path = B.
REQ-021 Stage-2 result input SHALL be the ALU result when stage-1 alu_mux=0, else the read path.
REQ-022 Stage 2 (execute/memory register) SHALL capture on each rising clk when reset is low: the stage-2 result into ALUresult_out, the store path into memData_out, and stage-1 wbs, mm, wm, ni, wme, reg_dest into the matching *_out.
REQ-023 am, alu_mux and ALUop SHALL be consumed in stage 1 and not forwarded.
REQ-024 Latency: a value presented on *_in before edge N SHALL appear on srcB_execute/flags after edge N and on stage-2 outputs after edge N+1; one new operation per cycle, no stall or bubble logic.
REQ-025 There SHALL be no handshake; both registers load unconditionally every cycle.

Reset
REQ-026 While reset is high at a rising edge, all stage-1 and stage-2 registers SHALL load 0; every registered output then reads 0.
REQ-027 After reset, stage 1 holds ALUop=000 with A=B=0, so flagZ=1 and flagN=0 until new data arrives.
REQ-028 Reset asserted mid-stream SHALL discard both in-flight operations in that edge; the first post-reset input appears at stage-2 outputs two edges after reset deasserts.

Verification
REQ-029 Reset for 2 cycles -> all outputs 0, flagZ=1, flagN=0.
REQ-030 ALUop=000, A=16'h7FFF, B=16'h0001, alu_mux=0 -> after 2 edges ALUresult_out=16'h8000; flagN=1, flagZ=0 during the execute cycle.
REQ-031 ALUop=001, A=B=16'h1234 -> result 0, flagZ=1; ALUop=001, A=0, B=1 -> result 16'hFFFF, flagN=1.
REQ-032 am=1, alu_mux=1, B=16'hABCD, wm=1, wme=1, reg_dest=4'hA -> ALUresult_out=0, memData_out=16'hABCD, wm_out=1, wme_out=1, reg_dest_out=4'hA.
REQ-033 am=0, alu_mux=1, B=16'h0040 -> ALUresult_out=16'h0040, memData_out=0; ALUop=101, A=1, B=16'h0013 -> result 16'h0008.
REQ-034 Back-to-back ops each cycle, then reset pulse between them -> the op issued before reset never appears at stage-2 outputs; srcB_execute tracks srcB_in with one-edge delay.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: two-register execute pipeline slice.
//   Stage 1 (decode/execute) captures all decode-stage inputs every cycle and
//   feeds a combinational 16-bit ALU.
//   Stage 2 (execute/memory) captures the selected result, the store data and
//   the control bits that travel on to the memory stage.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wbs/mm/wm/ni/wme_in              control bits carried to memory stage
//   ALUop_in, am_in, alu_mux_in      consumed in execute, not forwarded
//   reg_dest_in, srcA_in, srcB_in    destination index and operands
//   srcB_execute                     registered srcB (jump target)
//   flagN, flagZ                     combinational flags of the ALU result
//   *_out, ALUresult_out, memData_out, reg_dest_out   memory-stage registers
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_in,
  input  logic        mm_in,
  input  logic        wm_in,
  input  logic        ni_in,
  input  logic        wme_in,
  input  logic [2:0]  ALUop_in,
  input  logic        am_in,
  input  logic        alu_mux_in,
  input  logic [3:0]  reg_dest_in,
  input  logic [15:0] srcA_in,
  input  logic [15:0] srcB_in,
  output logic [15:0] srcB_execute,
  output logic        flagN,
  output logic        flagZ,
  output logic        wbs_out,
  output logic        mm_out,
  output logic        wm_out,
  output logic        ni_out,
  output logic        wme_out,
  output logic [15:0] ALUresult_out,
  output logic [15:0] memData_out,
  output logic [3:0]  reg_dest_out
);

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  // Stage-1 state
  logic        wbs_q, mm_q, wm_q, ni_q, wme_q;
  alu_op_e     alu_op_q;
  logic        am_q;
  logic        alu_mux_q;
  logic [3:0]  reg_dest_q;
  logic [15:0] src_a_q;

  // Execute-stage combinational signals
  logic [15:0] alu_result;
  logic [15:0] read_path;
  logic [15:0] store_path;
  logic [15:0] stage2_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_q        <= 1'b0;
      mm_q         <= 1'b0;
      wm_q         <= 1'b0;
      ni_q         <= 1'b0;
      wme_q        <= 1'b0;
      alu_op_q     <= ALU_ADD;
      am_q         <= 1'b0;
      alu_mux_q    <= 1'b0;
      reg_dest_q   <= '0;
      src_a_q      <= '0;
      srcB_execute <= '0;
    end else begin
      wbs_q        <= wbs_in;
      mm_q         <= mm_in;
      wm_q         <= wm_in;
      ni_q         <= ni_in;
      wme_q        <= wme_in;
      alu_op_q     <= alu_op_e'(ALUop_in);
      am_q         <= am_in;
      alu_mux_q    <= alu_mux_in;
      reg_dest_q   <= reg_dest_in;
      src_a_q      <= srcA_in;
      srcB_execute <= srcB_in;
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_op_q)
      ALU_ADD:   alu_result = src_a_q + srcB_execute;
      ALU_SUB:   alu_result = src_a_q - srcB_execute;
      ALU_AND:   alu_result = src_a_q & srcB_execute;
      ALU_OR:    alu_result = src_a_q | srcB_execute;
      ALU_XOR:   alu_result = src_a_q ^ srcB_execute;
      ALU_SHL:   alu_result = src_a_q << srcB_execute[3:0];
      ALU_SHR:   alu_result = src_a_q >> srcB_execute[3:0];
      ALU_PASSB: alu_result = srcB_execute;
      default:   alu_result = '0;
    endcase
  end

  // srcB goes either to the address/read path or to the store-data path,
  // never both; the unused side reads zero.
  always_comb begin
    read_path     = am_q ? '0 : srcB_execute;
    store_path    = am_q ? srcB_execute : '0;
    stage2_result = alu_mux_q ? read_path : alu_result;
  end

  assign flagN = alu_result[15];
  assign flagZ = (alu_result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_out       <= 1'b0;
      mm_out        <= 1'b0;
      wm_out        <= 1'b0;
      ni_out        <= 1'b0;
      wme_out       <= 1'b0;
      ALUresult_out <= '0;
      memData_out   <= '0;
      reg_dest_out  <= '0;
    end else begin
      wbs_out       <= wbs_q;
      mm_out        <= mm_q;
      wm_out        <= wm_q;
      ni_out        <= ni_q;
      wme_out       <= wme_q;
      ALUresult_out <= stage2_result;
      memData_out   <= store_path;
      reg_dest_out  <= reg_dest_q;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed literal checks followed by random
// traffic with occasional reset pulses, compared every cycle to a model.
module tb_execute_stage;

  typedef struct packed {
    logic        wbs, mm, wm, ni, wme;
    logic [2:0]  op;
    logic        am, mux;
    logic [3:0]  rd;
    logic [15:0] a, b;
  } in_t;

  typedef struct packed {
    logic        wbs, mm, wm, ni, wme;
    logic [15:0] res, mem;
    logic [3:0]  rd;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  in_t         cur;

  logic [15:0] srcB_execute;
  logic        flagN, flagZ;
  logic        wbs_out, mm_out, wm_out, ni_out, wme_out;
  logic [15:0] ALUresult_out, memData_out;
  logic [3:0]  reg_dest_out;

  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clk          (clk),
    .reset        (reset),
    .wbs_in       (cur.wbs),
    .mm_in        (cur.mm),
    .wm_in        (cur.wm),
    .ni_in        (cur.ni),
    .wme_in       (cur.wme),
    .ALUop_in     (cur.op),
    .am_in        (cur.am),
    .alu_mux_in   (cur.mux),
    .reg_dest_in  (cur.rd),
    .srcA_in      (cur.a),
    .srcB_in      (cur.b),
    .srcB_execute (srcB_execute),
    .flagN        (flagN),
    .flagZ        (flagZ),
    .wbs_out      (wbs_out),
    .mm_out       (mm_out),
    .wm_out       (wm_out),
    .ni_out       (ni_out),
    .wme_out      (wme_out),
    .ALUresult_out(ALUresult_out),
    .memData_out  (memData_out),
    .reg_dest_out (reg_dest_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ALU meaning written as plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned ua, ub, sh, r;
    ua = a;
    ub = b;
    sh = ub % 16;
    case (op)
      3'd0:    r = (ua + ub) % 65536;
      3'd1:    r = (ua + 65536 - ub) % 65536;
      3'd2:    r = ua & ub;
      3'd3:    r = ua | ub;
      3'd4:    r = ua ^ ub;
      3'd5:    r = (ua * (32'd1 << sh)) % 65536;
      3'd6:    r = ua / (32'd1 << sh);
      default: r = ub;
    endcase
    return 16'(r);
  endfunction

  function automatic out_t mem_stage_ref(input in_t s);
    out_t o;
    o.wbs = s.wbs;
    o.mm  = s.mm;
    o.wm  = s.wm;
    o.ni  = s.ni;
    o.wme = s.wme;
    o.rd  = s.rd;
    o.mem = s.am ? s.b : 16'h0000;
    if (s.mux) o.res = s.am ? 16'h0000 : s.b;
    else       o.res = alu_ref(s.op, s.a, s.b);
    return o;
  endfunction

  // Model: what is in execute and what is in memory stage, per edge.
  in_t  m_exec;
  out_t m_mem;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_exec  = '0;
      m_mem   = '0;
      m_valid = 1'b1;
    end else begin
      m_mem  = mem_stage_ref(m_exec);
      m_exec = cur;
    end
    #1;
    if (m_valid) begin
      logic [15:0] r;
      r = alu_ref(m_exec.op, m_exec.a, m_exec.b);
      check("srcB_execute", 32'(srcB_execute), 32'(m_exec.b));
      check("flagN", 32'(flagN), 32'(r[15]));
      check("flagZ", 32'(flagZ), 32'(r == 16'h0000));
      check("ALUresult_out", 32'(ALUresult_out), 32'(m_mem.res));
      check("memData_out", 32'(memData_out), 32'(m_mem.mem));
      check("reg_dest_out", 32'(reg_dest_out), 32'(m_mem.rd));
      check("ctrl_out", 32'({wbs_out, mm_out, wm_out, ni_out, wme_out}),
            32'({m_mem.wbs, m_mem.mm, m_mem.wm, m_mem.ni, m_mem.wme}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [2:0] op, input logic am, input logic mux,
                        input logic [15:0] a, input logic [15:0] b);
    cur.op  = op;
    cur.am  = am;
    cur.mux = mux;
    cur.a   = a;
    cur.b   = b;
  endtask

  initial begin
    reset = 1'b1;
    cur   = '0;

    // Model pinned to hand-computed values.
    check("ref_add_wrap", 32'(alu_ref(3'd0, 16'h7FFF, 16'h0001)), 32'h8000);
    check("ref_sub_neg", 32'(alu_ref(3'd1, 16'h0000, 16'h0001)), 32'hFFFF);
    check("ref_shl", 32'(alu_ref(3'd5, 16'h0001, 16'h0013)), 32'h0008);
    check("ref_shr", 32'(alu_ref(3'd6, 16'h8000, 16'h000F)), 32'h0001);

    // Two reset cycles
    tick();
    tick();
    check("rst_ALUresult", 32'(ALUresult_out), 32'h0);
    check("rst_memData", 32'(memData_out), 32'h0);
    check("rst_srcB", 32'(srcB_execute), 32'h0);
    check("rst_flags", 32'({flagN, flagZ}), 32'b01);
    check("rst_ctrl", 32'({wbs_out, mm_out, wm_out, ni_out, wme_out, reg_dest_out}), 32'h0);
    reset = 1'b0;

    set_op(3'b000, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    tick();
    check("add_flags_exec", 32'({flagN, flagZ}), 32'b10);
    check("add_srcB_exec", 32'(srcB_execute), 32'h0001);
    set_op(3'b001, 1'b0, 1'b0, 16'h1234, 16'h1234);
    tick();
    check("add_result", 32'(ALUresult_out), 32'h8000);
    check("sub_eq_flagZ", 32'({flagN, flagZ}), 32'b01);
    set_op(3'b001, 1'b0, 1'b0, 16'h0000, 16'h0001);
    tick();
    check("sub_eq_result", 32'(ALUresult_out), 32'h0);
    check("sub_neg_flagN", 32'({flagN, flagZ}), 32'b10);
    set_op(3'b000, 1'b1, 1'b1, 16'h0000, 16'hABCD);
    cur.wm  = 1'b1;
    cur.wme = 1'b1;
    cur.rd  = 4'hA;
    tick();
    check("sub_neg_result", 32'(ALUresult_out), 32'hFFFF);
    set_op(3'b000, 1'b0, 1'b1, 16'h0000, 16'h0040);
    cur.wm  = 1'b0;
    cur.wme = 1'b0;
    cur.rd  = 4'h3;
    tick();
    check("store_result", 32'(ALUresult_out), 32'h0);
    check("store_memData", 32'(memData_out), 32'hABCD);
    check("store_ctrl", 32'({wm_out, wme_out, reg_dest_out}), 32'({1'b1, 1'b1, 4'hA}));
    set_op(3'b101, 1'b0, 1'b0, 16'h0001, 16'h0013);
    tick();
    check("read_result", 32'(ALUresult_out), 32'h0040);
    check("read_memData", 32'(memData_out), 32'h0);
    set_op(3'b000, 1'b0, 1'b0, 16'h5555, 16'h0001);
    tick();
    check("shl_result", 32'(ALUresult_out), 32'h0008);

    // Mid-stream reset: the 0x5555+1 op now in execute must never emerge.
    set_op(3'b000, 1'b0, 1'b0, 16'h1111, 16'h2222);
    reset = 1'b1;
    tick();
    check("midrst_ALUresult", 32'(ALUresult_out), 32'h0);
    check("midrst_srcB", 32'(srcB_execute), 32'h0);
    reset = 1'b0;
    set_op(3'b111, 1'b0, 1'b0, 16'h0000, 16'h3333);
    tick();
    check("postrst_srcB", 32'(srcB_execute), 32'h3333);
    check("postrst_ALUresult_1", 32'(ALUresult_out), 32'h0);
    set_op(3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("postrst_ALUresult_2", 32'(ALUresult_out), 32'h3333);

    // Random traffic with sporadic resets
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 31) == 0);
      cur.wbs = 1'($urandom);
      cur.mm  = 1'($urandom);
      cur.wm  = 1'($urandom);
      cur.ni  = 1'($urandom);
      cur.wme = 1'($urandom);
      cur.op  = 3'($urandom);
      cur.am  = 1'($urandom);
      cur.mux = 1'($urandom);
      cur.rd  = 4'($urandom);
      cur.a   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cur.b   = ($urandom_range(0, 7) == 0) ? cur.a : 16'($urandom);
      tick();
    end
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
